// File: rtl/p18_input_conditioner_if.sv
// Pin-side bundle for p18_input_conditioner: raw inputs in, conditioned levels and edge pulses out.
// The master drives the raw inputs; the slave (the conditioner) drives the results.
interface p18_input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output in,
        input  out,
        input  rise,
        input  fall
    );

    modport slave (
        input  in,
        output out,
        output rise,
        output fall
    );
endinterface

// File: rtl/p18_input_conditioner.sv
// Per-channel synchroniser, debounce filter and optional edge detector.
// Macro P18_INPUT_CONDITIONER_EDGE_EN builds the rise/fall logic; when undefined both are tied low.
module p18_input_conditioner #(
    parameter int               WIDTH           = 4,
    parameter int               FF_COUNT        = 3,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    p18_input_conditioner_if.slave bus
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_out;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [FF_COUNT-1:0] r_sync_reg;
            logic                r_out_reg;

            // Only stage 0 ever samples the asynchronous pin.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync_reg <= {FF_COUNT{RESET_VALUE[gi]}};
                end else begin
                    r_sync_reg <= {r_sync_reg[FF_COUNT-2:0], bus.in[gi]};
                end
            end

            assign w_sync[gi] = r_sync_reg[FF_COUNT-1];
            assign w_out[gi]  = r_out_reg;

            if (DEBOUNCE_CYCLES >= 1) begin : g_debounce
                localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
                localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

                logic [CW-1:0] r_cnt_reg;
                logic [CW-1:0] w_cnt_next;
                logic          w_out_next;

                // A pending change is dropped the moment sync agrees with out again.
                always_comb begin
                    w_cnt_next = r_cnt_reg;
                    w_out_next = r_out_reg;
                    if (w_sync[gi] == r_out_reg) begin
                        w_cnt_next = '0;
                    end else if (r_cnt_reg == CNT_LAST) begin
                        w_out_next = w_sync[gi];
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt_reg + CW'(1);
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt_reg <= '0;
                        r_out_reg <= RESET_VALUE[gi];
                    end else begin
                        r_cnt_reg <= w_cnt_next;
                        r_out_reg <= w_out_next;
                    end
                end
            end else begin : g_bypass
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_out_reg <= RESET_VALUE[gi];
                    end else begin
                        r_out_reg <= w_sync[gi];
                    end
                end
            end
        end
    endgenerate

    assign bus.out = w_out;

`ifdef P18_INPUT_CONDITIONER_EDGE_EN
    logic [WIDTH-1:0] r_out_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_d_reg <= RESET_VALUE;
        end else begin
            r_out_d_reg <= w_out;
        end
    end

    assign bus.rise = w_out & ~r_out_d_reg;
    assign bus.fall = ~w_out & r_out_d_reg;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif

endmodule

// File: tb/tb_p18_input_conditioner.sv
// Bench for p18_input_conditioner: a debounced instance and a bypass instance with non-zero reset,
// checked each edge against a sample-history reference model plus directed constant checks.
module tb_p18_input_conditioner;

`ifdef P18_INPUT_CONDITIONER_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif
    localparam int FF = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    p18_input_conditioner_if #(.WIDTH(4)) bus_a ();
    p18_input_conditioner_if #(.WIDTH(4)) bus_b ();

    p18_input_conditioner #(
        .WIDTH(4), .FF_COUNT(3), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'b0000)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    p18_input_conditioner #(
        .WIDTH(4), .FF_COUNT(3), .DEBOUNCE_CYCLES(0), .RESET_VALUE(4'b1010)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int errors = 0;
    int checks = 0;
    int tick_no = 0;

    // Reference model: histories of raw samples and presented sync values since the last reset.
    logic [3:0] in_hist   [2][16];
    logic [3:0] sync_hist [2][16];
    int         n_edge    [2];
    logic [3:0] exp_out   [2];
    logic [3:0] exp_outd  [2];

    function automatic int deb_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic logic [3:0] rv_of(input int d);
        return (d == 0) ? 4'b0000 : 4'b1010;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last deb presented sync samples all disagree with out.
    task automatic model_step(input int d, input logic r, input logic [3:0] v);
        logic [3:0] sync_pres;
        logic [3:0] prev;
        logic [3:0] nxt;
        int         deb;
        int         n;
        logic       all_diff;
        deb = deb_of(d);
        if (r) begin
            n_edge[d]   = 0;
            exp_out[d]  = rv_of(d);
            exp_outd[d] = rv_of(d);
        end else begin
            n = n_edge[d];
            sync_pres = (n >= FF) ? in_hist[d][(n - FF) % 16] : rv_of(d);
            sync_hist[d][n % 16] = sync_pres;
            in_hist[d][n % 16]   = v;
            prev = exp_out[d];
            nxt  = prev;
            for (int ch = 0; ch < 4; ch++) begin
                if (deb == 0) begin
                    nxt[ch] = sync_pres[ch];
                end else begin
                    all_diff = (n + 1 >= deb);
                    for (int j = 0; j < deb; j++) begin
                        if (all_diff && sync_hist[d][(n - j) % 16][ch] == prev[ch]) all_diff = 1'b0;
                    end
                    if (all_diff) nxt[ch] = ~prev[ch];
                end
            end
            exp_outd[d] = prev;
            exp_out[d]  = nxt;
            n_edge[d]   = n + 1;
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] er;
        logic [3:0] ef;
        reset    = r;
        bus_a.in = a;
        bus_b.in = b;
        @(posedge clk);
        model_step(0, r, a);
        model_step(1, r, b);
        #1;
        tick_no++;
        $display("tick %0d rst=%b a_in=%b a_out=%b a_rise=%b a_fall=%b | b_in=%b b_out=%b b_rise=%b b_fall=%b",
                 tick_no, r, a, bus_a.out, bus_a.rise, bus_a.fall, b, bus_b.out, bus_b.rise, bus_b.fall);
        check("a_out", bus_a.out, exp_out[0]);
        er = EDGE_EN ? (exp_out[0] & ~exp_outd[0]) : 4'b0000;
        ef = EDGE_EN ? (~exp_out[0] & exp_outd[0]) : 4'b0000;
        check("a_rise", bus_a.rise, er);
        check("a_fall", bus_a.fall, ef);
        check("b_out", bus_b.out, exp_out[1]);
        er = EDGE_EN ? (exp_out[1] & ~exp_outd[1]) : 4'b0000;
        ef = EDGE_EN ? (~exp_out[1] & exp_outd[1]) : 4'b0000;
        check("b_rise", bus_b.rise, er);
        check("b_fall", bus_b.fall, ef);
    endtask

    initial begin
        logic       tog;
        logic [3:0] a_cur;
        logic [3:0] m;
        int         nr;
        int         nf;
        tog = 1'b0;

        // Reset values with all inputs high.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'b1111, 4'b1111);
            check("rst_a_out", bus_a.out, 4'b0000);
            check("rst_a_edges", bus_a.rise | bus_a.fall, 4'b0000);
            check("rst_b_out", bus_b.out, 4'b1010);
        end
        tick(1'b0, 4'b0000, {tog, 3'b010});
        check("post_rst_a_out", bus_a.out, 4'b0000);
        check("post_rst_a_edges", bus_a.rise | bus_a.fall, 4'b0000);
        check("post_rst_b_out", bus_b.out, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            tog = ~tog;
            tick(1'b0, 4'b0000, {tog, 3'b010});
        end

        // Clean step on channel 0; B's channel 3 toggles every cycle.
        for (int i = 0; i < 9; i++) begin
            tog = ~tog;
            tick(1'b0, 4'b0001, {tog, 3'b010});
            check("step_out0", {3'b000, bus_a.out[0]}, {3'b000, (i >= 6)});
            check("step_rise0", {3'b000, bus_a.rise[0]}, {3'b000, EDGE_EN && (i == 6)});
            check("step_out_hi", {1'b0, bus_a.out[3:1]}, 4'b0000);
            check("b_toggle_edge", {3'b000, bus_b.rise[3] ^ bus_b.fall[3]}, {3'b000, EDGE_EN});
        end

        // Glitch of 3 cycles on channel 1 is rejected.
        nr = 0;
        nf = 0;
        for (int i = 0; i < 13; i++) begin
            tick(1'b0, (i < 3) ? 4'b0011 : 4'b0001, $urandom_range(0, 15));
            nr += bus_a.rise[1];
            nf += bus_a.fall[1];
            check("glitch_out1", {3'b000, bus_a.out[1]}, 4'b0000);
        end
        check("glitch_edges1", 4'(nr + nf), 4'd0);

        // Pulse of exactly 4 cycles is accepted, then released.
        nr = 0;
        nf = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, (i < 4) ? 4'b0011 : 4'b0001, $urandom_range(0, 15));
            nr += bus_a.rise[1];
            nf += bus_a.fall[1];
            check("pulse4_out1", {3'b000, bus_a.out[1]}, {3'b000, (i >= 6) && (i < 10)});
        end
        check("pulse4_rises", 4'(nr), EDGE_EN ? 4'd1 : 4'd0);
        check("pulse4_falls", 4'(nf), EDGE_EN ? 4'd1 : 4'd0);

        // Reset mid-debounce on channel 2.
        for (int i = 0; i < 4; i++) tick(1'b0, 4'b0101, $urandom_range(0, 15));
        tick(1'b1, 4'b0101, $urandom_range(0, 15));
        check("middeb_rst_out", bus_a.out, 4'b0000);
        check("middeb_rst_b", bus_b.out, 4'b1010);
        for (int j = 1; j <= 9; j++) begin
            tick(1'b0, 4'b0101, $urandom_range(0, 15));
            check("middeb_out2", {3'b000, bus_a.out[2]}, {3'b000, (j >= 7)});
        end

        // Randomised phase: frequent short glitches and occasional resets.
        a_cur = 4'b0101;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 4) == 0);
            a_cur = a_cur ^ m;
            tick(($urandom_range(0, 99) == 0), a_cur, $urandom_range(0, 15));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p18_input_conditioner.md
# p18_input_conditioner

Multi-channel input conditioner that generalises the single-bit synchroniser: each of `WIDTH` asynchronous inputs passes through an `FF_COUNT`-stage synchroniser, then a per-channel debounce filter, and optionally an edge detector. It sits between the top-level input pins (buttons, switches, external strobes) and the core logic, which sees only clean, glitch-free, clock-aligned levels and single-cycle edge pulses.

## Interface

Parameters:
- `WIDTH`, default 4: number of independent channels; legal range ≥ 1.
- `FF_COUNT`, default 3: synchroniser stages per channel; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new level must persist before it is accepted; 0 means no debounce filtering.
- `RESET_VALUE`, default `'0` (`WIDTH` bits): per-channel level loaded into all state on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in`, input, `WIDTH`: asynchronous raw inputs.
- `out`, output, `WIDTH`: synchronised, debounced levels (registered).
- `rise`, output, `WIDTH`: one-cycle pulse when `out[i]` goes 0→1.
- `fall`, output, `WIDTH`: one-cycle pulse when `out[i]` goes 1→0.

## Operation

- Channels are fully independent. No state is shared between them.
- **Synchroniser:** a per-channel shift chain, `FF_COUNT` bits long. `in[i]` enters stage 0. The last stage is `sync[i]`.
- **Debounce, when `DEBOUNCE_CYCLES` ≥ 1:**
  - Each channel has a counter, `$clog2(DEBOUNCE_CYCLES+1)` bits wide, and a registered level `out[i]`.
  - On each edge, if `sync[i] == out[i]`, the counter clears to 0.
  - Otherwise, if the counter equals `DEBOUNCE_CYCLES-1`, then `out[i] <= sync[i]` and the counter clears to 0.
  - Otherwise the counter increments.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`, so it has no wrap-around.
  - Any return of `sync[i]` to `out[i]` before acceptance discards the pending change. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `out`.
- **Debounce, when `DEBOUNCE_CYCLES` == 0:** `out[i]` is a register loaded with `sync[i]` every edge. No counter is instantiated.
- **Edge detection:**
  - A per-channel register `out_d[i]` holds `out[i]` delayed by one cycle.
  - `rise = out & ~out_d` and `fall = ~out & out_d`. Both are combinational from registers.
  - `rise[i]` and `fall[i]` are never both high.
- **Reset:**
  - All synchroniser stages, `out`, and `out_d` load `RESET_VALUE`; all counters load 0.
  - Consequently `rise` and `fall` are 0 during reset and in the first cycle after it.
  - Reset mid-debounce abandons any pending change; reset dominates all other updates.

## Timing

- Define edge k as the first rising edge at which `in[i]` is sampled at its new value.
- `sync[i]` shows the new value after edge k+`FF_COUNT`-1.
- `out[i]` changes after edge k+`FF_COUNT`-1+`DEBOUNCE_CYCLES`, and after edge k+`FF_COUNT` when `DEBOUNCE_CYCLES`=0.
- `rise`/`fall` assert in the same cycle `out` takes its new value and last exactly one cycle.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles of stable `sync`. A `sync` pulse exactly `DEBOUNCE_CYCLES` cycles long is accepted; one cycle shorter is rejected.
- Throughput: one accepted transition per channel at most every `DEBOUNCE_CYCLES` cycles (every cycle when `DEBOUNCE_CYCLES`=0).
- `in` carries no timing relation to `clk`. Only stage 0 samples it.

## Configuration

- Macro: `P18_INPUT_CONDITIONER_EDGE_EN`.
- **Defined:** the `out_d` registers and the `rise`/`fall` logic are built as described above.
- **Undefined:**
  - No `out_d` registers are instantiated.
  - `rise` and `fall` are tied to `'0`.
  - `out` behaviour and latency are unchanged.
  - The ports remain present, so the instantiating code is identical in both builds.

## Test plan

All scenarios use `WIDTH`=4, `FF_COUNT`=3, `DEBOUNCE_CYCLES`=4 and `RESET_VALUE`=4'b0000 unless noted.

- **Reset values:** hold `reset`=1 for 3 cycles with `in`=4'b1111, then release → `out`=0000 and `rise`=`fall`=0 during reset and in the first cycle after release.
- **Clean step:** `in[0]` 0→1, held, first sampled at edge k → `out[0]`=1 after edge k+6. `rise[0]`=1 for exactly that one cycle. `out[3:1]` stays 000.
- **Glitch rejection:**
  - `in[1]` high for 3 cycles, then low → `out[1]` stays 0, and no `rise`/`fall`.
  - `in[1]` high for 4 cycles → accepted, giving a `rise[1]` pulse and later a `fall[1]` pulse.
- **Reset mid-debounce:** `in[2]` high. Assert `reset` for 1 cycle at edge k+4 (counter mid-count), keep `in[2]` high → `out[2]`=0 immediately after. The full 3+4-edge latency restarts from release, and `out[2]`=1 at release edge+7.
- **Bypass and non-zero reset** (`DEBOUNCE_CYCLES`=0, `RESET_VALUE`=4'b1010):
  - After reset, `out`=1010.
  - `in[3]` toggling every cycle → `out[3]` follows with a 3-edge delay, and `rise[3]`/`fall[3]` alternate each cycle.
- **Macro undefined:** rerun the clean-step scenario → `out` timing identical to the defined build; `rise`=`fall`=0 throughout.
